// File: rtl/prog_fsm_engine.sv
// prog_fsm_engine: table-driven FSM whose transitions and Moore outputs
// are loaded at runtime through a configuration port.
module prog_fsm_engine #(
  parameter  int N_STATES   = 8,
  parameter  int IN_W       = 3,
  parameter  int OUT_W      = 2,
  parameter  int N_TRANS    = 16,
  parameter  int INIT_STATE = 0,
  localparam int SW         = $clog2(N_STATES),
  localparam int TW         = $clog2(N_TRANS),
  localparam int CFG_W      = 1 + 2*SW + 2*IN_W + OUT_W
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_run,
  input  logic             i_soft_init,
  input  logic [IN_W-1:0]  i_in,
  output logic [OUT_W-1:0] o_out,
  output logic [SW-1:0]    o_state,
  output logic             o_fired,
  output logic [TW-1:0]    o_fired_idx,
  output logic             o_err,
  input  logic             i_cfg_we,
  input  logic             i_cfg_sel,
  input  logic [TW-1:0]    i_cfg_addr,
  input  logic [CFG_W-1:0] i_cfg_data
);

  localparam logic [SW-1:0] INIT_S = SW'(INIT_STATE);

  localparam int MEALY_LO = 0;
  localparam int VAL_LO   = OUT_W;
  localparam int CARE_LO  = OUT_W + IN_W;
  localparam int DST_LO   = OUT_W + 2*IN_W;
  localparam int SRC_LO   = DST_LO + SW;
  localparam int VLD_BIT  = CFG_W - 1;

  logic             r_tvld   [N_TRANS];
  logic [SW-1:0]    r_tsrc   [N_TRANS];
  logic [SW-1:0]    r_tdst   [N_TRANS];
  logic [IN_W-1:0]  r_tcare  [N_TRANS];
  logic [IN_W-1:0]  r_tval   [N_TRANS];
  logic [OUT_W-1:0] r_tmealy [N_TRANS];
  logic [OUT_W-1:0] r_moore  [N_STATES];

  logic [SW-1:0]    r_state;
  logic             r_err;

  logic             w_cfg_vld;
  logic [SW-1:0]    w_cfg_src;
  logic [SW-1:0]    w_cfg_dst;
  logic [IN_W-1:0]  w_cfg_care;
  logic [IN_W-1:0]  w_cfg_val;
  logic [OUT_W-1:0] w_cfg_mealy;

  logic [N_TRANS-1:0] w_hit;
  logic             w_fired;
  logic [TW-1:0]    w_idx;
  logic [SW-1:0]    w_dst;
  logic [OUT_W-1:0] w_mealy;
  logic             w_dst_ok;
  logic [OUT_W-1:0] w_moore;
  logic [SW-1:0]    w_next;
  logic             w_err_set;

  assign w_cfg_vld   = i_cfg_data[VLD_BIT];
  assign w_cfg_src   = i_cfg_data[SRC_LO +: SW];
  assign w_cfg_dst   = i_cfg_data[DST_LO +: SW];
  assign w_cfg_care  = i_cfg_data[CARE_LO +: IN_W];
  assign w_cfg_val   = i_cfg_data[VAL_LO +: IN_W];
  assign w_cfg_mealy = i_cfg_data[MEALY_LO +: OUT_W];

  // Table storage; Moore writes beyond the state count match no entry
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int k = 0; k < N_TRANS; k++) begin
        r_tvld[k]   <= 1'b0;
        r_tsrc[k]   <= '0;
        r_tdst[k]   <= '0;
        r_tcare[k]  <= '0;
        r_tval[k]   <= '0;
        r_tmealy[k] <= '0;
      end
      for (int s = 0; s < N_STATES; s++) begin
        r_moore[s] <= '0;
      end
    end else if (i_cfg_we) begin
      for (int k = 0; k < N_TRANS; k++) begin
        if (!i_cfg_sel && int'(i_cfg_addr) == k) begin
          r_tvld[k]   <= w_cfg_vld;
          r_tsrc[k]   <= w_cfg_src;
          r_tdst[k]   <= w_cfg_dst;
          r_tcare[k]  <= w_cfg_care;
          r_tval[k]   <= w_cfg_val;
          r_tmealy[k] <= w_cfg_mealy;
        end
      end
      for (int s = 0; s < N_STATES; s++) begin
        if (i_cfg_sel && int'(i_cfg_addr) == s) begin
          r_moore[s] <= w_cfg_mealy;
        end
      end
    end
  end

  always_comb begin
    w_hit = '0;
    for (int k = 0; k < N_TRANS; k++) begin
      w_hit[k] = r_tvld[k] &&
                 (r_tsrc[k] == r_state) &&
                 ((i_in & r_tcare[k]) == (r_tval[k] & r_tcare[k]));
    end
  end

  // Lowest index wins: scan downward so the last hit kept is the lowest
  always_comb begin
    w_fired = 1'b0;
    w_idx   = '0;
    w_dst   = '0;
    w_mealy = '0;
    for (int k = N_TRANS - 1; k >= 0; k--) begin
      if (w_hit[k]) begin
        w_fired = 1'b1;
        w_idx   = TW'(k);
        w_dst   = r_tdst[k];
        w_mealy = r_tmealy[k];
      end
    end
  end

  assign w_dst_ok = int'(w_dst) < N_STATES;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= INIT_S;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_err_set) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next    = r_state;
    w_err_set = 1'b0;
    if (i_soft_init) begin
      w_next = INIT_S;
    end else if (i_run && w_fired) begin
      if (w_dst_ok) begin
        w_next = w_dst;
      end else begin
        w_next    = INIT_S;
        w_err_set = 1'b1;
      end
    end
  end

  always_comb begin
    w_moore = '0;
    for (int s = 0; s < N_STATES; s++) begin
      if (r_state == SW'(s)) begin
        w_moore = r_moore[s];
      end
    end
  end

  always_comb begin
    o_out       = w_moore | (w_fired ? w_mealy : '0);
    o_state     = r_state;
    o_fired     = w_fired;
    o_fired_idx = w_idx;
    o_err       = r_err;
  end

endmodule

// File: doc/prog_fsm_engine.md
Name: prog_fsm_engine

Overview:
- Runtime-programmable, table-driven finite state machine.
- Generalises the team's fixed FSM descriptions (state list, guarded transitions, Moore and Mealy outputs) into one parametrised block.
- The state count, input width, output width and transition-table depth are parameters.
- Transitions and outputs are loaded through a configuration port, so one instance can run any machine that fits the table.

Parameters:
- N_STATES, 8, number of states; SW = $clog2(N_STATES).
- IN_W, 3, width of the guard input vector.
- OUT_W, 2, width of the output vector.
- N_TRANS, 16, transition-table entries; TW = $clog2(N_TRANS).
- INIT_STATE, 0, state entered on reset or soft_init.
- CFG_W, derived, = 1 + 2*SW + 2*IN_W + OUT_W.

Ports:
- clock, input, 1, single clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high.
- run, input, 1, when 1 the FSM may transition this cycle; when 0 the state holds.
- soft_init, input, 1, synchronous return to INIT_STATE; does not clear the tables.
- in, input, IN_W, guard inputs.
- out, output, OUT_W, Moore output OR'ed with the fired Mealy output.
- state, output, SW, current state register.
- fired, output, 1, a transition matched this cycle (combinational).
- fired_idx, output, TW, index of the matched entry; 0 when fired=0.
- err, output, 1, sticky flag for an illegal destination.
- cfg_we, input, 1, configuration write strobe.
- cfg_sel, input, 1, 0 = transition table, 1 = Moore table.
- cfg_addr, input, TW, entry index (transition) or state index (Moore).
- cfg_data, input, CFG_W, write data. Transition layout MSB to LSB: {valid, src[SW], dst[SW], care[IN_W], val[IN_W], mealy[OUT_W]}. Moore writes use bits [OUT_W-1:0].

Behaviour:
- Reset (synchronous, active-high): state=INIT_STATE, err=0, all transition entries valid=0, all Moore entries 0. Hence out=0 and fired=0 in the cycle after reset.
- Match rule: entry k matches when valid_k, src_k==state, and (in & care_k)==(val_k & care_k).
  - care=0 means an unconditional transition.
  - Multiple matches resolve to the lowest index (priority encoder), giving a deterministic resolution of overlapping guards.
- fired and fired_idx are combinational from state, in and the tables. fired is asserted independent of run.
- Next state:
  - reset > soft_init > (run & fired ? dst : state).
  - No match means the state holds (implicit self-loop).
- Illegal destination: dst >= N_STATES, possible when N_STATES is not a power of 2. If such an entry fires with run=1, the state goes to INIT_STATE and err is set. err clears only on reset.
- out = moore[state] | (fired ? mealy_k : 0).
  - The Mealy term is present whenever fired=1, even with run=0. It is a combinational path from in to out.
  - Entries with mealy=0 give pure Moore behaviour.
- Latency: a transition is visible on state one cycle after the qualifying in/run. The Moore part of out follows state with zero extra delay.
- Config writes:
  - Take effect at the clock edge. Matching in the write cycle uses the old contents.
  - A write to the entry currently matching does not disturb the transition taken in that cycle.
  - A Moore write with cfg_addr >= N_STATES is ignored.
  - Writes are accepted regardless of run and soft_init; the same-edge reset discards them.
- soft_init and run=1 with a match in the same cycle: soft_init wins and the transition is dropped.
- Reset mid-operation: everything returns to the reset values above; the tables must be reloaded.
- No latches. One registered state; the tables are flop arrays.

Test Plan:
- Reset then idle -> state=0, out=2'b00, fired=0, err=0 for 5 cycles with arbitrary in.
- Load entry0 {v=1, src=0, dst=1, care=3'b011, val=3'b011, mealy=2'b01} and Moore[1]=2'b10; in=3'b011, run=1 -> fired=1, fired_idx=0, out=2'b01 that cycle; next cycle state=1, out=2'b10.
- Priority: entries 2 and 5 both match from state 1 (dst 3 vs 4) -> fired_idx=2, state becomes 3. Invalidate entry 2 -> the next match goes to state 4.
- run=0 with a matching guard -> fired=1 and Mealy out present, state unchanged. Assert soft_init with run=1 and a match -> state=INIT_STATE.
- N_STATES=6 build: entry dst=7 fires -> state=0, err=1 and stays 1 through later transitions until reset.
- Config write to the currently matching entry (change dst 2->5) in the same cycle it fires -> state=2. A later re-entry to the source state and match -> state=5.
